// File: rtl/epc_pkg.sv
// Shared types and constants for the even-parity serial link receiver.
package epc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } epc_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int unsigned EPC_DATA_W_DEFAULT = 4;

    // The counter must be able to hold DATA_W itself, hence the +1.
    function automatic int unsigned epc_cnt_w(input int unsigned data_w);
        return $clog2(data_w + 1);
    endfunction

    localparam int unsigned EPC_CNT_W = epc_cnt_w(EPC_DATA_W_DEFAULT);

endpackage

// File: rtl/serial_even_parity_checker.sv
// Receive side of the even-parity serial link: start, DATA_W bits LSB first, parity, stop.
module serial_even_parity_checker
    import epc_pkg::*;
#(
    parameter int unsigned DATA_W = EPC_DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              parity_err,
    output logic              frame_err,
    output logic              out_valid,
    output logic              busy
);

    localparam int unsigned CntW = epc_cnt_w(DATA_W);

    epc_state_t        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              acc_q, acc_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              valid_q, valid_d;
    logic [DATA_W:0]   shift_ext;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        acc_d     = acc_q;
        data_d    = data_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        valid_d   = 1'b0;
        // New bit enters at the MSB so the first bit ends up at [0].
        shift_ext = {bit_in, shift_q};

        if (bit_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (bit_in == START_BIT) begin
                        state_d = StData;
                        cnt_d   = '0;
                        acc_d   = 1'b0;
                    end
                end
                StData: begin
                    shift_d = shift_ext[DATA_W:1];
                    acc_d   = acc_q ^ bit_in;
                    cnt_d   = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(DATA_W - 1)) begin
                        state_d = StParity;
                    end
                end
                StParity: begin
                    acc_d   = acc_q ^ bit_in;
                    state_d = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    data_d  = shift_q;
                    perr_d  = acc_q;
                    ferr_d  = (bit_in != STOP_BIT);
                    valid_d = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shift_q <= '0;
            acc_q   <= 1'b0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            valid_q <= valid_d;
        end
    end

    assign data_out   = data_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign out_valid  = valid_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_serial_even_parity_checker.sv
// Self-checking bench for serial_even_parity_checker with DATA_W=4.
module tb_serial_even_parity_checker;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         bit_in = 1'b1;
    logic         bit_valid = 1'b0;
    logic [W-1:0] data_out;
    logic         parity_err;
    logic         frame_err;
    logic         out_valid;
    logic         busy;

    int nchecks = 0;
    int nerrors = 0;
    int vcount = 0;
    int cycle = 0;
    int pulse_q[$];

    serial_even_parity_checker #(.DATA_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .data_out   (data_out),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .out_valid  (out_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Count out_valid pulses and remember the cycle each one was seen in.
    always @(posedge clk) begin
        cycle++;
        if (out_valid === 1'b1) begin
            vcount++;
            pulse_q.push_back(cycle);
        end
    end

    // Reference: even parity error is the odd count of ones over data plus parity bit.
    function automatic logic model_perr(input logic [W-1:0] d, input logic p);
        return logic'((int'($countones(d)) + int'(p)) % 2);
    endfunction

    // Drives a whole frame, leaving the bench at the negedge where the result is visible.
    task automatic run_frame(input logic [W-1:0] d, input logic p, input logic s,
                             input int gap, output int busy_low);
        logic [W+2:0] f;
        f = {s, p, d, 1'b0};
        busy_low = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            if (i > 0 && busy !== 1'b1) busy_low++;
            bit_valid = 1'b1;
            bit_in    = f[i];
            if (i < W + 2) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    bit_valid = 1'b0;
                    bit_in    = 1'($urandom);
                    if (busy !== 1'b1) busy_low++;
                end
            end
        end
        @(negedge clk);
        bit_valid = 1'b0;
        bit_in    = 1'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bit_valid = 1'($urandom);
            bit_in    = 1'($urandom);
        end
        @(negedge clk);
        bit_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        nchecks += 5;
        if (data_out !== 4'b0000) begin
            nerrors++; $display("FAIL reset_data_out got=%b want=0000", data_out);
        end
        if (parity_err !== 1'b0) begin
            nerrors++; $display("FAIL reset_parity_err got=%b want=0", parity_err);
        end
        if (frame_err !== 1'b0) begin
            nerrors++; $display("FAIL reset_frame_err got=%b want=0", frame_err);
        end
        if (out_valid !== 1'b0) begin
            nerrors++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        if (busy !== 1'b0) begin
            nerrors++; $display("FAIL reset_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] td [3] = '{4'b1011, 4'b1100, 4'b1111};
        logic         tp [3] = '{1'b1, 1'b1, 1'b0};
        logic         ts [3] = '{1'b1, 1'b1, 1'b0};
        int           bl;
        int           v0;
        for (int k = 0; k < 3; k++) begin
            v0 = vcount;
            run_frame(td[k], tp[k], ts[k], 0, bl);
            nchecks += 7;
            if (out_valid !== 1'b1) begin
                nerrors++; $display("FAIL dir%0d_out_valid got=%b want=1", k, out_valid);
            end
            if (data_out !== td[k]) begin
                nerrors++; $display("FAIL dir%0d_data got=%b want=%b", k, data_out, td[k]);
            end
            if (parity_err !== model_perr(td[k], tp[k])) begin
                nerrors++;
                $display("FAIL dir%0d_parity_err got=%b want=%b", k, parity_err,
                         model_perr(td[k], tp[k]));
            end
            if (frame_err !== !ts[k]) begin
                nerrors++; $display("FAIL dir%0d_frame_err got=%b want=%b", k, frame_err, !ts[k]);
            end
            if (busy !== 1'b0) begin
                nerrors++; $display("FAIL dir%0d_busy_after got=%b want=0", k, busy);
            end
            @(negedge clk);
            if (out_valid !== 1'b0) begin
                nerrors++; $display("FAIL dir%0d_pulse_width got=%b want=0", k, out_valid);
            end
            if (vcount - v0 !== 1) begin
                nerrors++; $display("FAIL dir%0d_pulse_count got=%0d want=1", k, vcount - v0);
            end
        end
    endtask

    task automatic test_gaps();
        int bl;
        int v0;
        v0 = vcount;
        run_frame(4'b1011, 1'b1, 1'b1, 3, bl);
        nchecks += 6;
        if (bl !== 0) begin
            nerrors++; $display("FAIL gap_busy_low got=%0d want=0", bl);
        end
        if (out_valid !== 1'b1) begin
            nerrors++; $display("FAIL gap_out_valid got=%b want=1", out_valid);
        end
        if (data_out !== 4'b1011) begin
            nerrors++; $display("FAIL gap_data got=%b want=1011", data_out);
        end
        if (parity_err !== 1'b0 || frame_err !== 1'b0) begin
            nerrors++; $display("FAIL gap_errs got=%b%b want=00", parity_err, frame_err);
        end
        @(negedge clk);
        if (out_valid !== 1'b0) begin
            nerrors++; $display("FAIL gap_pulse_width got=%b want=0", out_valid);
        end
        if (vcount - v0 !== 1) begin
            nerrors++; $display("FAIL gap_pulse_count got=%0d want=1", vcount - v0);
        end
    endtask

    task automatic test_mid_reset();
        logic [2:0] part;
        int         bl;
        int         v0;
        part = 3'b010;
        v0 = vcount;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bit_valid = 1'b1;
            bit_in    = part[i];
        end
        @(negedge clk);
        bit_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        nchecks += 2;
        if (busy !== 1'b0) begin
            nerrors++; $display("FAIL mrst_busy got=%b want=0", busy);
        end
        if (data_out !== 4'b0000) begin
            nerrors++; $display("FAIL mrst_data got=%b want=0000", data_out);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            @(negedge clk);
            bit_valid = 1'b0;
            nchecks++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                nerrors++; $display("FAIL mrst_idle%0d busy=%b valid=%b want=0 0", i, busy, out_valid);
            end
        end
        run_frame(4'b0000, 1'b0, 1'b1, 0, bl);
        nchecks += 3;
        if (out_valid !== 1'b1 || data_out !== 4'b0000) begin
            nerrors++; $display("FAIL mrst_frame valid=%b data=%b want=1 0000", out_valid, data_out);
        end
        if (parity_err !== 1'b0 || frame_err !== 1'b0) begin
            nerrors++; $display("FAIL mrst_errs got=%b%b want=00", parity_err, frame_err);
        end
        @(negedge clk);
        if (vcount - v0 !== 1) begin
            nerrors++; $display("FAIL mrst_pulse_count got=%0d want=1", vcount - v0);
        end
    endtask

    task automatic test_back_to_back();
        logic [W+2:0] f1;
        logic [W+2:0] f2;
        int           v0;
        int           n;
        f1 = {1'b1, 1'b1, 4'b1011, 1'b0};
        f2 = {1'b1, 1'b0, 4'b1100, 1'b0};
        v0 = vcount;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            bit_valid = 1'b1;
            bit_in    = f1[i];
        end
        @(negedge clk);
        nchecks += 2;
        if (out_valid !== 1'b1 || data_out !== 4'b1011) begin
            nerrors++; $display("FAIL b2b_first valid=%b data=%b want=1 1011", out_valid, data_out);
        end
        if (parity_err !== 1'b0 || frame_err !== 1'b0) begin
            nerrors++; $display("FAIL b2b_first_errs got=%b%b want=00", parity_err, frame_err);
        end
        bit_valid = 1'b1;
        bit_in    = f2[0];
        for (int i = 1; i < W + 3; i++) begin
            @(negedge clk);
            bit_valid = 1'b1;
            bit_in    = f2[i];
        end
        @(negedge clk);
        bit_valid = 1'b0;
        nchecks += 4;
        if (out_valid !== 1'b1 || data_out !== 4'b1100) begin
            nerrors++; $display("FAIL b2b_second valid=%b data=%b want=1 1100", out_valid, data_out);
        end
        if (parity_err !== 1'b0 || frame_err !== 1'b0) begin
            nerrors++; $display("FAIL b2b_second_errs got=%b%b want=00", parity_err, frame_err);
        end
        @(negedge clk);
        if (vcount - v0 !== 2) begin
            nerrors++; $display("FAIL b2b_pulse_count got=%0d want=2", vcount - v0);
        end
        n = pulse_q.size();
        if (n < 2 || pulse_q[n-1] - pulse_q[n-2] < 2) begin
            nerrors++; $display("FAIL b2b_pulse_spacing got=%0d want>=2",
                                (n < 2) ? 0 : pulse_q[n-1] - pulse_q[n-2]);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] d;
        logic         p;
        logic         s;
        int           bl;
        int           v0;
        for (int k = 0; k < 24; k++) begin
            d = W'($urandom);
            p = 1'($urandom);
            s = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
                @(negedge clk);
                bit_valid = 1'b1;
                bit_in    = 1'b1;
            end
            v0 = vcount;
            run_frame(d, p, s, int'($urandom_range(0, 2)), bl);
            nchecks += 4;
            if (out_valid !== 1'b1 || data_out !== d) begin
                nerrors++;
                $display("FAIL rnd%0d_data valid=%b data=%b want=1 %b", k, out_valid, data_out, d);
            end
            if (parity_err !== model_perr(d, p)) begin
                nerrors++;
                $display("FAIL rnd%0d_parity_err got=%b want=%b", k, parity_err, model_perr(d, p));
            end
            if (frame_err !== !s) begin
                nerrors++; $display("FAIL rnd%0d_frame_err got=%b want=%b", k, frame_err, !s);
            end
            @(negedge clk);
            if (vcount - v0 !== 1) begin
                nerrors++; $display("FAIL rnd%0d_pulse_count got=%0d want=1", k, vcount - v0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_gaps();
        test_mid_reset();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
